// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM breathing sequencer.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Ramp/hold tick generator: a down-counter with a terminal-count compare.
// The tick is registered, so the first one lands TICK_DIV cycles after en
// rises and later ones follow every TICK_DIV cycles.
module pwm_tick_gen #(
  parameter logic [23:0] TICK_DIV = 24'd100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [23:0] cnt_q;
  logic        tick_q;

  // Count down while enabled, pulse at terminal count, reload otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= TICK_DIV - 24'd1;
      tick_q <= 1'b0;
    end else if (cnt_q == 24'd0) begin
      cnt_q  <= TICK_DIV - 24'd1;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q - 24'd1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-profile sequencer feeding one PWM channel's duty/start/oe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | channel off, config port open, waiting for go
// RAMP_UP   | duty += step each tick, saturating at DUTY_MAX
// HOLD_HIGH | duty at DUTY_MAX for cfg_hold+1 ticks
// RAMP_DOWN | duty -= step each tick, clamped at 0
// HOLD_LOW  | duty at 0 for cfg_hold+1 ticks, then next breath or done
module pwm_breath_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter logic [23:0] TICK_DIV = 24'd100000,
  parameter logic [7:0]  DUTY_MAX = 8'd100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_step,
  input  logic [15:0]       cfg_hold,
  input  logic [7:0]        cfg_cycles,
  input  logic              go,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              pwm_start,
  output logic              pwm_oe,
  output logic              busy,
  output logic              done
);

  state_t             state_q;
  logic [DUTY_W-1:0]  duty_q;
  logic               start_q;
  logic               oe_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         step_q;
  logic [15:0]        hold_q;
  logic [7:0]         cycles_q;
  logic [15:0]        hold_cnt_q;
  logic [7:0]         breath_q;

  logic               tick;
  logic               cfg_take_d;
  logic [DUTY_W:0]    up_sum_d;
  logic [DUTY_W-1:0]  up_duty_d;
  logic [DUTY_W-1:0]  down_duty_d;
  logic               last_breath_d;
  logic [7:0]         breath_inc_d;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  assign cfg_ready  = (state_q == IDLE);
  assign cfg_take_d = cfg_valid && (state_q == IDLE);

  // Next duty values for the ramps; the 9-bit sum keeps the up-ramp from wrapping.
  always_comb begin
    up_sum_d      = {1'b0, duty_q} + {1'b0, step_q};
    up_duty_d     = (up_sum_d >= {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum_d[DUTY_W-1:0];
    down_duty_d   = (duty_q > step_q) ? (duty_q - step_q) : '0;
    last_breath_d = (cycles_q != 8'd0) && (({1'b0, breath_q} + 9'd1) == {1'b0, cycles_q});
    breath_inc_d  = (breath_q == 8'hFF) ? breath_q : (breath_q + 8'd1);
  end

  // Config capture; only open in IDLE. A zero step is stored as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= 8'd1;
      hold_q   <= 16'd0;
      cycles_q <= 8'd0;
    end else if (cfg_take_d) begin
      step_q   <= (cfg_step == 8'd0) ? 8'd1 : cfg_step;
      hold_q   <= cfg_hold;
      cycles_q <= cfg_cycles;
    end
  end

  // Sequencer FSM with registered channel outputs; abort outranks any tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      start_q    <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_cnt_q <= 16'd0;
      breath_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort) begin
        state_q <= IDLE;
        duty_q  <= '0;
        start_q <= 1'b0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (go) begin
              state_q  <= RAMP_UP;
              duty_q   <= '0;
              start_q  <= 1'b1;
              oe_q     <= 1'b1;
              busy_q   <= 1'b1;
              breath_q <= 8'd0;
            end
          end
          RAMP_UP: begin
            if (tick) begin
              duty_q <= up_duty_d;
              if (up_duty_d == DUTY_MAX) begin
                state_q    <= HOLD_HIGH;
                hold_cnt_q <= hold_q;
              end
            end
          end
          HOLD_HIGH: begin
            if (tick) begin
              if (hold_cnt_q == 16'd0) begin
                state_q <= RAMP_DOWN;
              end else begin
                hold_cnt_q <= hold_cnt_q - 16'd1;
              end
            end
          end
          RAMP_DOWN: begin
            if (tick) begin
              duty_q <= down_duty_d;
              if (down_duty_d == '0) begin
                state_q    <= HOLD_LOW;
                hold_cnt_q <= hold_q;
              end
            end
          end
          HOLD_LOW: begin
            if (tick) begin
              if (hold_cnt_q != 16'd0) begin
                hold_cnt_q <= hold_cnt_q - 16'd1;
              end else if (last_breath_d) begin
                state_q <= IDLE;
                start_q <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                breath_q <= breath_inc_d;
                state_q  <= RAMP_UP;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            duty_q  <= '0;
            start_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_cycle = duty_q;
  assign pwm_start  = start_q;
  assign pwm_oe     = oe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: expected duty steps (value and cycle gap since
// the previous change) are queued when a run is launched and consumed by a
// monitor each time the DUT's duty output moves.
module tb_pwm_breath_ctrl;

  localparam int TD   = 4;
  localparam int DMAX = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_step = 8'd0;
  logic [15:0] cfg_hold = 16'd0;
  logic [7:0]  cfg_cycles = 8'd0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_ready;
  logic [7:0]  duty_cycle;
  logic        pwm_start;
  logic        pwm_oe;
  logic        busy;
  logic        done;

  typedef struct {
    int duty;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_duty = 0;
  int   sb_last_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  bit   sb_en = 1'b0;
  exp_t mon_e;

  pwm_breath_ctrl #(
    .TICK_DIV (24'd4),
    .DUTY_MAX (8'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_hold   (cfg_hold),
    .cfg_cycles (cfg_cycles),
    .go         (go),
    .abort      (abort),
    .duty_cycle (duty_cycle),
    .pwm_start  (pwm_start),
    .pwm_oe     (pwm_oe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumer: every duty change must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (sb_en) begin
      if (int'(duty_cycle) != last_duty) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: duty moved %0d -> %0d, nothing expected", last_duty, duty_cycle);
        end else begin
          mon_e = sb_q.pop_front();
          if (int'(duty_cycle) !== mon_e.duty) begin
            n_bad++;
            $display("FAIL sb_duty: got %0d expected %0d", duty_cycle, mon_e.duty);
          end
          if (mon_e.gap != 0) begin
            n_cmp++;
            if ((cyc - sb_last_cyc) !== mon_e.gap) begin
              n_bad++;
              $display("FAIL sb_gap: duty %0d after %0d cycles, expected %0d", duty_cycle, cyc - sb_last_cyc, mon_e.gap);
            end
          end
        end
        sb_last_cyc = cyc;
        last_duty   = int'(duty_cycle);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input int d, input int g);
    exp_t e;
    e.duty = d;
    e.gap  = g;
    sb_q.push_back(e);
  endtask

  // Reference profile: duty values and their spacing for a whole run.
  task automatic push_model(input int step, input int hold, input int cycles);
    int s;
    int d;
    int g;
    s = (step == 0) ? 1 : step;
    d = 0;
    g = TD + 2;
    for (int b = 0; b < cycles; b++) begin
      do begin
        d = (d + s >= DMAX) ? DMAX : d + s;
        push_exp(d, g);
        g = TD;
      end while (d != DMAX);
      g = (hold + 2) * TD;
      do begin
        d = (d > s) ? d - s : 0;
        push_exp(d, g);
        g = TD;
      end while (d != 0);
      g = (hold + 2) * TD;
    end
  endtask

  task automatic drive(input int step, input int hold, input int cycles,
                       input bit do_cfg, input bit do_go);
    @(negedge clk);
    cfg_valid  = do_cfg;
    cfg_step   = step[7:0];
    cfg_hold   = hold[15:0];
    cfg_cycles = cycles[7:0];
    go         = do_go;
    if (do_go) sb_last_cyc = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
    go        = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle} !== {5'b00001, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_hold: got %b expected %b", {busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle}, {5'b00001, 8'd0});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle} !== {5'b00001, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_release: got %b expected %b", {busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle}, {5'b00001, 8'd0});
    end
    last_duty = 0;
    sb_en     = 1'b1;
  endtask

  // Full runs: plain ramp, saturating step with holds, zero step over two breaths.
  task automatic test_profiles;
    int t_step[3]   = '{25, 30, 0};
    int t_hold[3]   = '{0, 2, 0};
    int t_cycles[3] = '{1, 1, 2};
    int d0;
    bit fin;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      drive(t_step[k], t_hold[k], t_cycles[k], 1'b1, 1'b0);
      push_model(t_step[k], t_hold[k], t_cycles[k]);
      drive(0, 0, 0, 1'b0, 1'b1);
      fin = 1'b0;
      for (int i = 0; i < 4000 && !fin; i++) begin
        @(negedge clk);
        fin = (sb_q.size() == 0) && (done_cnt != d0);
      end
      n_cmp++;
      if (!fin) begin
        n_bad++;
        $display("FAIL profile%0d_timeout: %0d steps left, done seen %0d, required 0 left and done", k, sb_q.size(), done_cnt - d0);
        sb_q.delete();
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ((done_cnt - d0) !== 1) begin
        n_bad++;
        $display("FAIL profile%0d_done_count: got %0d expected 1", k, done_cnt - d0);
      end
      n_cmp++;
      if ((done_cyc - sb_last_cyc) !== (t_hold[k] + 1) * TD) begin
        n_bad++;
        $display("FAIL profile%0d_done_gap: got %0d expected %0d", k, done_cyc - sb_last_cyc, (t_hold[k] + 1) * TD);
      end
      n_cmp++;
      if ({busy, pwm_start, pwm_oe, cfg_ready, duty_cycle} !== {4'b0001, 8'd0}) begin
        n_bad++;
        $display("FAIL profile%0d_idle: got %b expected %b", k, {busy, pwm_start, pwm_oe, cfg_ready, duty_cycle}, {4'b0001, 8'd0});
      end
    end
  endtask

  // Abort issued on the very cycle HOLD_HIGH sees its tick.
  task automatic test_abort;
    int d0;
    drive(25, 0, 0, 1'b1, 1'b0);
    push_exp(25, TD + 2);
    push_exp(50, TD);
    push_exp(75, TD);
    push_exp(100, TD);
    drive(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_ramp_timeout: %0d steps left, required 0", sb_q.size());
      sb_q.delete();
    end
    while (cyc < sb_last_cyc + TD - 1) @(negedge clk);
    push_exp(0, TD);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, pwm_start, pwm_oe, cfg_ready, duty_cycle} !== {4'b0001, 8'd0}) begin
      n_bad++;
      $display("FAIL abort_idle: got %b expected %b", {busy, pwm_start, pwm_oe, cfg_ready, duty_cycle}, {4'b0001, 8'd0});
    end
    repeat (3 * TD) @(negedge clk);
    n_cmp++;
    if ((done_cnt != d0) || (sb_q.size() != 0)) begin
      n_bad++;
      $display("FAIL abort_no_done: done pulses %0d, pending %0d, required 0 and 0", done_cnt - d0, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Config refused while busy; config and go together use the new config.
  task automatic test_cfg_busy;
    int d0;
    bit fin;
    d0 = done_cnt;
    drive(25, 0, 1, 1'b1, 1'b0);
    push_model(25, 0, 1);
    drive(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 50 && duty_cycle != 8'd25; i++) @(negedge clk);
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_step   = 8'd50;
    cfg_hold   = 16'd5;
    cfg_cycles = 8'd3;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_ready_busy: got %b expected 0", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(negedge clk);
      fin = (sb_q.size() == 0) && (done_cnt != d0);
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL cfg_busy_timeout: %0d steps left, done seen %0d, required 0 left and done", sb_q.size(), done_cnt - d0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ((done_cnt - d0) !== 1 || (done_cyc - sb_last_cyc) !== TD) begin
      n_bad++;
      $display("FAIL cfg_busy_done: pulses %0d gap %0d, expected 1 and %0d", done_cnt - d0, done_cyc - sb_last_cyc, TD);
    end

    d0 = done_cnt;
    push_model(50, 0, 1);
    drive(50, 0, 1, 1'b1, 1'b1);
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(negedge clk);
      fin = (sb_q.size() == 0) && (done_cnt != d0);
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL cfg_go_timeout: %0d steps left, done seen %0d, required 0 left and done", sb_q.size(), done_cnt - d0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ((done_cnt - d0) !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_go_done: pulses %0d busy %b, expected 1 and 0", done_cnt - d0, busy);
    end
  endtask

  // Asynchronous reset in the middle of a ramp restores the default step of 1.
  task automatic test_reset_midrun;
    drive(25, 0, 0, 1'b1, 1'b0);
    push_exp(25, TD + 2);
    push_exp(50, TD);
    drive(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrun_ramp_timeout: %0d steps left, required 0", sb_q.size());
      sb_q.delete();
    end
    push_exp(0, 0);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle} !== {5'b00001, 8'd0}) begin
      n_bad++;
      $display("FAIL midrun_async_reset: got %b expected %b", {busy, pwm_start, pwm_oe, done, cfg_ready, duty_cycle}, {5'b00001, 8'd0});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(1, TD + 2);
    push_exp(2, TD);
    drive(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrun_default_step: %0d steps left, required 0", sb_q.size());
      sb_q.delete();
    end
    push_exp(0, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, cfg_ready, duty_cycle} !== {2'b01, 8'd0}) begin
      n_bad++;
      $display("FAIL midrun_abort: got %b expected %b", {busy, cfg_ready, duty_cycle}, {2'b01, 8'd0});
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_profiles;
    test_abort;
    test_cfg_busy;
    test_reset_midrun;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_steps: got %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
